// File: rtl/np_mm_feeder.sv
// np_mm_feeder: sequences feature/weight reads into the FFN MAC and hands out each dot product.
// Rotates through NUM_BUF frame buffers, producing NUM_NEURONS results per frame.

`ifndef FFN_IN_BITWIDTH
`define FFN_IN_BITWIDTH 15
`endif
`ifndef FFN_OUT_BITWIDTH
`define FFN_OUT_BITWIDTH 31
`endif

module np_mm_feeder #(
    parameter int unsigned NUM_BUF     = 2,
    parameter int unsigned VEC_LEN     = 64,
    parameter int unsigned NUM_NEURONS = 16,
    parameter int unsigned FADDR_W     = 6,
    parameter int unsigned WADDR_W     = 10
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [NUM_BUF-1:0]                    frame_rdy,
    output logic [NUM_BUF-1:0]                    reading_frame,
    output logic                                  frame_done,
    output logic [FADDR_W-1:0]                    buf_addr,
    output logic [WADDR_W-1:0]                    weight_addr,
    input  logic [`FFN_IN_BITWIDTH:0]             buf_data,
    input  logic [`FFN_IN_BITWIDTH:0]             weight_data,
    output logic [`FFN_IN_BITWIDTH:0]             mac_fp,
    output logic [`FFN_IN_BITWIDTH:0]             mac_w,
    output logic                                  mac_en,
    input  logic [`FFN_OUT_BITWIDTH:0]            mac_sum,
    output logic [`FFN_OUT_BITWIDTH:0]            out_sum,
    output logic [((NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1)-1:0] out_neuron,
    output logic                                  out_valid,
    input  logic                                  out_ready
);

    localparam int unsigned K_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int unsigned N_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(VEC_LEN - 1);
    localparam logic [N_W-1:0] N_LAST = N_W'(NUM_NEURONS - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ISSUE,
        DRAIN,
        CAPTURE,
        RESULT
    } state_t;

    state_t         state;
    logic [K_W-1:0] k;
    logic [N_W-1:0] n;

    // Memory read data goes straight to the MAC; mac_en is timed to match it.
    assign mac_fp = buf_data;
    assign mac_w  = weight_data;

    // Sequencer: address issue, MAC enable timing, result capture and frame rotation.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            reading_frame <= NUM_BUF'(1);
            frame_done    <= 1'b0;
            mac_en        <= 1'b0;
            out_valid     <= 1'b0;
            buf_addr      <= '0;
            weight_addr   <= '0;
            out_sum       <= '0;
            out_neuron    <= '0;
            k             <= '0;
            n             <= '0;
        end else begin
            frame_done <= 1'b0;
            // Enable trails address issue by the one-cycle memory read latency.
            mac_en     <= (state == ISSUE);
            case (state)
                IDLE: begin
                    if (|(frame_rdy & reading_frame)) begin
                        buf_addr <= '0;
                        state    <= CLEAR;
                    end
                end
                CLEAR: begin
                    k     <= '0;
                    state <= ISSUE;
                end
                ISSUE: begin
                    // Addresses hold on the last element; the weight pointer steps to
                    // the next neuron base when the result is accepted.
                    if (k == K_LAST) begin
                        k     <= '0;
                        state <= DRAIN;
                    end else begin
                        k           <= k + K_W'(1);
                        buf_addr    <= buf_addr + FADDR_W'(1);
                        weight_addr <= weight_addr + WADDR_W'(1);
                    end
                end
                DRAIN: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    out_sum    <= mac_sum;
                    out_neuron <= n;
                    out_valid  <= 1'b1;
                    state      <= RESULT;
                end
                RESULT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        buf_addr  <= '0;
                        if (n == N_LAST) begin
                            n             <= '0;
                            weight_addr   <= '0;
                            reading_frame <= {reading_frame[NUM_BUF-2:0], reading_frame[NUM_BUF-1]};
                            frame_done    <= 1'b1;
                            state         <= IDLE;
                        end else begin
                            n           <= n + N_W'(1);
                            weight_addr <= weight_addr + WADDR_W'(1);
                            state       <= CLEAR;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_np_mm_feeder.sv
// tb_np_mm_feeder: table-driven frames with a result scoreboard, plus backpressure,
// latency, buffer-select, mid-frame reset and K=1 sequences.

`ifndef FFN_IN_BITWIDTH
`define FFN_IN_BITWIDTH 15
`endif
`ifndef FFN_OUT_BITWIDTH
`define FFN_OUT_BITWIDTH 31
`endif

module tb_np_mm_feeder;

    localparam int unsigned IW = `FFN_IN_BITWIDTH + 1;
    localparam int unsigned OW = `FFN_OUT_BITWIDTH + 1;
    localparam int unsigned KA = 4;

    logic clock;
    logic reset;

    // DUT A: K=4, two neurons per frame
    logic [1:0]           frame_rdy_a, rf_a;
    logic                 done_a, en_a, oval_a, ordy_a;
    logic [5:0]           baddr_a;
    logic [9:0]           waddr_a;
    logic [IW-1:0]        bdata_a, wdata_a, fp_a, w_a;
    logic signed [OW-1:0] msum_a;
    logic [OW-1:0]        osum_a;
    logic [0:0]           oneu_a;

    // DUT B: K=1, single neuron
    logic [1:0]           frame_rdy_b, rf_b;
    logic                 done_b, en_b, oval_b, ordy_b;
    logic [5:0]           baddr_b;
    logic [9:0]           waddr_b;
    logic [IW-1:0]        bdata_b, wdata_b, fp_b, w_b;
    logic signed [OW-1:0] msum_b;
    logic [OW-1:0]        osum_b;
    logic [0:0]           oneu_b;

    logic [IW-1:0] fbuf_a [2][4];
    logic [IW-1:0] wmem_a [8];
    logic [IW-1:0] fbuf_b [2];
    logic [IW-1:0] wmem_b;

    np_mm_feeder #(.NUM_BUF(2), .VEC_LEN(4), .NUM_NEURONS(2), .FADDR_W(6), .WADDR_W(10)) u_dut_a (
        .clock(clock), .reset(reset), .frame_rdy(frame_rdy_a), .reading_frame(rf_a),
        .frame_done(done_a), .buf_addr(baddr_a), .weight_addr(waddr_a),
        .buf_data(bdata_a), .weight_data(wdata_a), .mac_fp(fp_a), .mac_w(w_a),
        .mac_en(en_a), .mac_sum(msum_a), .out_sum(osum_a), .out_neuron(oneu_a),
        .out_valid(oval_a), .out_ready(ordy_a)
    );

    np_mm_feeder #(.NUM_BUF(2), .VEC_LEN(1), .NUM_NEURONS(1), .FADDR_W(6), .WADDR_W(10)) u_dut_b (
        .clock(clock), .reset(reset), .frame_rdy(frame_rdy_b), .reading_frame(rf_b),
        .frame_done(done_b), .buf_addr(baddr_b), .weight_addr(waddr_b),
        .buf_data(bdata_b), .weight_data(wdata_b), .mac_fp(fp_b), .mac_w(w_b),
        .mac_en(en_b), .mac_sum(msum_b), .out_sum(osum_b), .out_neuron(oneu_b),
        .out_valid(oval_b), .out_ready(ordy_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memories with one-cycle registered read
    always_ff @(posedge clock) begin
        bdata_a <= fbuf_a[rf_a[1]][baddr_a[1:0]];
        wdata_a <= wmem_a[waddr_a[2:0]];
        bdata_b <= fbuf_b[rf_b[1]];
        wdata_b <= wmem_b;
    end

    // MAC reference: accumulate when enabled, zero otherwise
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            msum_a <= '0;
            msum_b <= '0;
        end else begin
            msum_a <= en_a ? msum_a + OW'($signed(fp_a)) * OW'($signed(w_a)) : '0;
            msum_b <= en_b ? msum_b + OW'($signed(fp_b)) * OW'($signed(w_b)) : '0;
        end
    end

    typedef struct {
        int feat[4];
        int wt[2][4];
        int exp_sum[2];
    } frame_vec_t;

    typedef struct {
        int sum;
        int neuron;
    } exp_t;

    frame_vec_t tbl[4];
    exp_t       sb_q[$];
    int checks = 0;
    int fails  = 0;
    int en_cnt_a = 0;
    int en_cnt_b = 0;
    int done_cnt_a = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: compare each accepted result against the queued expectation
    always @(negedge clock) begin
        if (!reset) begin
            en_cnt_a = 0;
            en_cnt_b = 0;
        end else begin
            if (en_a) en_cnt_a++;
            if (en_b) en_cnt_b++;
            if (done_a) done_cnt_a++;
            if (oval_a && ordy_a) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("out_sum", $signed(osum_a), e.sum);
                    check("out_neuron", oneu_a, e.neuron);
                    check("mac_en_cycles", en_cnt_a, KA);
                end
                en_cnt_a = 0;
            end
        end
    end

    task automatic check_reset_a(input string tag);
        check({tag, "_reading_frame"}, rf_a, 1);
        check({tag, "_frame_done"}, done_a, 0);
        check({tag, "_mac_en"}, en_a, 0);
        check({tag, "_out_valid"}, oval_a, 0);
        check({tag, "_buf_addr"}, baddr_a, 0);
        check({tag, "_weight_addr"}, waddr_a, 0);
        check({tag, "_out_sum"}, osum_a, 0);
        check({tag, "_out_neuron"}, oneu_a, 0);
    endtask

    task automatic load_a(input int idx, input logic [1:0] sel);
        for (int i = 0; i < 4; i++) fbuf_a[sel[1]][i] = IW'(tbl[idx].feat[i]);
        for (int nn = 0; nn < 2; nn++)
            for (int i = 0; i < 4; i++) wmem_a[nn*4 + i] = IW'(tbl[idx].wt[nn][i]);
    endtask

    task automatic run_frame(input int idx, input logic [1:0] sel, input bit bp);
        int  cyc;
        bit  seen;
        logic [1:0] nxt;
        nxt = {sel[0], sel[1]};
        check("reading_frame_pre", rf_a, sel);
        load_a(idx, sel);
        for (int nn = 0; nn < 2; nn++) sb_q.push_back(exp_t'{tbl[idx].exp_sum[nn], nn});
        if (bp) ordy_a = 1'b0;
        frame_rdy_a = sel;
        if (bp) begin
            cyc = 0;
            seen = 1'b0;
            while (!seen && cyc < 50) begin
                @(posedge clock); #1;
                cyc++;
                seen = oval_a;
            end
            check("latency_edges", cyc, 8);
            repeat (10) begin
                @(posedge clock); #1;
                check("bp_out_valid", oval_a, 1);
                check("bp_out_sum", $signed(osum_a), tbl[idx].exp_sum[0]);
                check("bp_mac_en", en_a, 0);
                check("bp_buf_addr", baddr_a, 3);
                check("bp_weight_addr", waddr_a, 3);
            end
            ordy_a = 1'b1;
            @(posedge clock); #1;
            check("clear_out_valid", oval_a, 0);
            check("clear_buf_addr", baddr_a, 0);
            check("clear_weight_addr", waddr_a, 4);
            check("clear_mac_en", en_a, 0);
        end
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(posedge clock); #1;
            cyc++;
            seen = done_a;
        end
        check("frame_done_seen", seen, 1);
        check("reading_frame_post", rf_a, nxt);
        check("sb_drained", sb_q.size(), 0);
        frame_rdy_a = 2'b00;
        @(posedge clock); #1;
        check("frame_done_one_cycle", done_a, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        bit  seen;
        tbl[0].feat = '{1, 2, 3, 4};
        tbl[0].wt   = '{'{5, 6, 7, 8}, '{1, 1, 1, 1}};
        tbl[0].exp_sum = '{70, 10};
        tbl[1].feat = '{1, 1, 1, 1};
        tbl[1].wt   = '{'{1, 1, 1, 1}, '{6, 6, 6, 6}};
        tbl[1].exp_sum = '{4, 24};
        tbl[2].feat = '{-1, 2, -3, 4};
        tbl[2].wt   = '{'{2, 2, 2, 2}, '{-1, -1, -1, -1}};
        tbl[2].exp_sum = '{4, -2};
        tbl[3].feat = '{100, -50, 7, 0};
        tbl[3].wt   = '{'{3, 4, -2, 9}, '{0, 0, 0, 0}};
        tbl[3].exp_sum = '{86, 0};
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 4; i++) fbuf_a[b][i] = '0;
            fbuf_b[b] = '0;
        end
        for (int i = 0; i < 8; i++) wmem_a[i] = '0;
        wmem_b = '0;

        reset = 1'b0;
        frame_rdy_a = 2'b00;
        frame_rdy_b = 2'b00;
        ordy_a = 1'b1;
        ordy_b = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_reset_a("por");
        reset = 1'b1;

        // Ready on the non-selected buffer must not start a frame
        frame_rdy_a = 2'b10;
        repeat (6) @(posedge clock);
        #1;
        check("idle_mac_en_count", en_cnt_a, 0);
        check("idle_out_valid", oval_a, 0);
        check("idle_reading_frame", rf_a, 2'b01);
        frame_rdy_a = 2'b00;
        @(posedge clock); #1;

        // Ping-pong across three frames; first one under backpressure
        run_frame(0, 2'b01, 1'b1);
        run_frame(1, 2'b10, 1'b0);
        run_frame(2, 2'b01, 1'b0);
        check("frame_done_count_3", done_cnt_a, 3);

        // Reset in the middle of ISSUE (element 2) on buffer 1
        load_a(3, 2'b10);
        frame_rdy_a = 2'b10;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 50) begin
            @(posedge clock); #1;
            cyc++;
            seen = (baddr_a == 6'd2);
        end
        check("reached_issue_k2", seen, 1);
        reset = 1'b0;
        #1;
        check_reset_a("mid_reset");
        frame_rdy_a = 2'b00;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        run_frame(3, 2'b01, 1'b0);
        check("frame_done_count_4", done_cnt_a, 4);

        // K=1 boundary on DUT B
        fbuf_b[0] = IW'(7);
        wmem_b = IW'(-3);
        frame_rdy_b = 2'b01;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 50) begin
            @(posedge clock); #1;
            cyc++;
            seen = oval_b;
        end
        check("k1_latency_edges", cyc, 5);
        check("k1_out_sum", $signed(osum_b), -21);
        check("k1_out_neuron", oneu_b, 0);
        check("k1_mac_en_cycles", en_cnt_b, 1);
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(posedge clock); #1;
            cyc++;
            seen = done_b;
        end
        check("k1_frame_done", seen, 1);
        check("k1_reading_frame", rf_b, 2'b10);
        frame_rdy_b = 2'b00;
        repeat (2) @(posedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
